// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its command-side stepper.
package counter_pkg;

    // Counter width, shared by the counter, the stepper and their benches.
    localparam int CNT_W = 8;

    // Direction encoding on the counter's D pin.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Half of the counter range. A distance of exactly this much is a tie
    // between the two directions, and a tie goes up.
    localparam logic [CNT_W-1:0] HALF_RANGE = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WAIT,
        DONE,
        ERR
    } stepper_state_t;

    // Steps needed to go from cur to tgt counting up, modulo 2^CNT_W.
    function automatic logic [CNT_W-1:0] dist_up(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
        return tgt - cur;
    endfunction

    // Direction of the shortest wrap-around path from cur to tgt.
    // Up wins when the two paths have equal length.
    // Zero distance also reports up.
    function automatic logic shortest_dir(input logic [CNT_W-1:0] cur,
                                          input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] d;
        d = dist_up(cur, tgt);
        return (d > HALF_RANGE) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/counter_stepper.sv
// Command-side driver for the up/down counter: takes a target over a
// valid/ready handshake, steps the counter one count at a time along the
// shortest wrap-around path, and checks every step against the expected value.
module counter_stepper
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_data,
    input  logic         abort,
    input  logic [W-1:0] count_in,
    output logic         E,
    output logic         D,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] steps
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    stepper_state_t state;
    logic           dir_q;
    logic [W-1:0]   steps_q;
    logic [W-1:0]   tgt_q;
    logic [W-1:0]   exp_q;

    logic accept;
    logic step_adv;

    // Transfer conditions shared by the control and data registers.
    assign accept   = (state == IDLE) && tgt_valid;
    assign step_adv = (state == STEP) && !abort;

    // Control FSM: state, latched direction and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir_q   <= DIR_UP;
            steps_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        steps_q <= '0;
                        dir_q   <= shortest_dir(count_in, tgt_data);
                        state   <= (tgt_data == count_in) ? DONE : STEP;
                    end
                end
                STEP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        steps_q <= steps_q + ONE;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Abort outranks the step check so a cancelled command
                    // never reports completion or mismatch.
                    if (abort) begin
                        state <= IDLE;
                    end else if (count_in != exp_q) begin
                        state <= ERR;
                    end else if (count_in == tgt_q) begin
                        state <= DONE;
                    end else begin
                        state <= STEP;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Target and expected-count registers: only meaningful while busy, so
    // they are loaded on accept and never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_q <= tgt_data;
            exp_q <= count_in;
        end else if (step_adv) begin
            exp_q <= (dir_q == DIR_DOWN) ? (exp_q - ONE) : (exp_q + ONE);
        end
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign E         = (state == STEP);
    assign done      = (state == DONE) || (state == ERR);
    assign err       = (state == ERR);
    assign D         = dir_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_counter_stepper.sv
// Bench for counter_stepper: a behavioural up/down counter closes the loop,
// a vector table drives shortest-path commands, and hand-written sequences
// cover counter reset, abort and back-to-back commands.
module tb_counter_stepper;
    import counter_pkg::*;

    localparam int W = CNT_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         tgt_valid;
    logic         tgt_ready;
    logic [W-1:0] tgt_data;
    logic         abort;
    logic [W-1:0] cnt;
    logic         E;
    logic         D;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] steps;

    logic         cnt_rst;
    logic         load_en;
    logic [W-1:0] load_val;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] start;
        logic [W-1:0] target;
        int           exp_d;
        int           exp_steps;
    } vec_t;

    typedef struct {
        int d;
        int steps;
        int err;
        int cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    // Counter under control: updates at the edge ending a cycle with E=1.
    always_ff @(posedge clk) begin
        if (rst || cnt_rst)  cnt <= '0;
        else if (load_en)    cnt <= load_val;
        else if (E)          cnt <= D ? cnt - 8'd1 : cnt + 8'd1;
    end

    counter_stepper #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .abort     (abort),
        .count_in  (cnt),
        .E         (E),
        .D         (D),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .steps     (steps)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic load_cnt(input logic [W-1:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // One command from the table; the expected record is queued at accept
    // and popped when the stepper signals completion.
    task automatic run_cmd(input vec_t v);
        exp_t e;
        exp_t g;
        int   e_cnt;
        bit   e_bad;
        bit   got;
        load_cnt(v.start);
        @(negedge clk);
        check("ready_before", int'(tgt_ready), 1);
        tgt_valid = 1'b1;
        tgt_data  = v.target;
        sb.push_back('{d: v.exp_d, steps: v.exp_steps, err: 0, cyc: 2 * v.exp_steps + 1});
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        e_cnt = 0;
        e_bad = 1'b0;
        got   = 1'b0;
        g     = '{d: 0, steps: 0, err: 0, cyc: 0};
        for (int k = 1; k <= 400 && !got; k++) begin
            @(negedge clk);
            if (E) begin
                if (k % 2 == 1) e_cnt++;
                else            e_bad = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                g   = '{d: int'(D), steps: int'(steps), err: int'(err), cyc: k};
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got no done expected done for target %0d", v.target);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check("dir", g.d, e.d);
            check("steps", g.steps, e.steps);
            check("err", g.err, e.err);
            check("done_cycle", g.cyc, e.cyc);
            check("e_pulses", e_cnt, e.steps);
            check("e_even_cycle", int'(e_bad), 0);
            check("final_count", int'(cnt), int'(v.target));
        end
        @(negedge clk);
        check("ready_after", int'(tgt_ready), 1);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        exp_t e;
        int   saw_done;
        int   done_cyc;
        int   acc;
        int   last_done;
        int   bad;
        logic [W-1:0] tgts[3];

        vecs[0] = '{start: 8'd10,  target: 8'd13,  exp_d: 0, exp_steps: 3};
        vecs[1] = '{start: 8'd0,   target: 8'd255, exp_d: 1, exp_steps: 1};
        vecs[2] = '{start: 8'd255, target: 8'd0,   exp_d: 0, exp_steps: 1};
        vecs[3] = '{start: 8'd0,   target: 8'd128, exp_d: 0, exp_steps: 128};
        vecs[4] = '{start: 8'd0,   target: 8'd129, exp_d: 1, exp_steps: 127};
        vecs[5] = '{start: 8'd42,  target: 8'd42,  exp_d: 0, exp_steps: 0};
        vecs[6] = '{start: 8'd200, target: 8'd5,   exp_d: 0, exp_steps: 61};
        vecs[7] = '{start: 8'd5,   target: 8'd200, exp_d: 1, exp_steps: 61};

        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        abort     = 1'b0;
        cnt_rst   = 1'b0;
        load_en   = 1'b0;
        load_val  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_ready", int'(tgt_ready), 1);
        check("rst_E", int'(E), 0);
        check("rst_D", int'(D), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_steps", int'(steps), 0);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Counter reset during the third WAIT of a 5-step up command from 20.
        load_cnt(8'd20);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = 8'd25;
        sb.push_back('{d: 0, steps: 4, err: 1, cyc: 9});
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        done_cyc = 0;
        for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("crst_wait3_E", int'(E), 0);
                cnt_rst = 1'b1;
            end
            if (k == 7) cnt_rst = 1'b0;
            if (done) begin
                done_cyc = k;
                e = sb.pop_front();
                check("crst_err", int'(err), e.err);
                check("crst_steps", int'(steps), e.steps);
                check("crst_done_cycle", k, e.cyc);
            end
        end
        cnt_rst = 1'b0;
        if (done_cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL crst_timeout: got no done expected err pulse");
            void'(sb.pop_front());
        end
        @(negedge clk);
        check("crst_idle_ready", int'(tgt_ready), 1);
        check("crst_idle_err", int'(err), 0);

        // Abort during STEP of a 10-step up command from 50.
        load_cnt(8'd50);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = 8'd60;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        saw_done = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (k == 5) begin
                check("abort_in_step", int'(E), 1);
                check("abort_steps_before", int'(steps), 2);
                abort = 1'b1;
            end
        end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        if (done) saw_done = 1;
        check("abort_E_low", int'(E), 0);
        check("abort_no_done", saw_done, 0);
        check("abort_ready", int'(tgt_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_steps_kept", int'(steps), 2);

        // Back-to-back commands with tgt_valid held high: 0 -> 5 -> 2 -> 5.
        load_cnt(8'd0);
        tgts[0]   = 8'd5;
        tgts[1]   = 8'd2;
        tgts[2]   = 8'd5;
        acc       = 0;
        last_done = -1;
        bad       = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (tgt_ready && busy) bad = 1;
            if (done) last_done = c;
            if (tgt_ready) begin
                if (acc > 0) check("b2b_ready_after_done", c, last_done + 1);
                if (acc < 3) begin
                    tgt_valid = 1'b1;
                    tgt_data  = tgts[acc];
                    acc++;
                end else begin
                    tgt_valid = 1'b0;
                    break;
                end
            end
        end
        tgt_valid = 1'b0;
        check("b2b_accepts", acc, 3);
        check("b2b_ready_busy_overlap", bad, 0);
        check("b2b_final_count", int'(cnt), 5);
        check("b2b_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
